day3_rucksack_engine: RTL and testbench

DAY3_RUCKSACK_ENGINE -- requirements
Module: day3_rucksack_engine

---
 rtl/day3_rucksack_engine.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_day3_rucksack_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/day3_rucksack_engine.sv
// Rucksack priority engine.
// Walks a zero-terminated item list held in an external asynchronous ROM,
// one word per clock, and accumulates the priority of the single item that
// is common to both halves of a line (mode 0) or to every line of a group
// of GROUP lines (mode 1). Any anomaly raises a sticky err flag.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start after reset
// SCAN      | mode 0: measure the current line length up to its terminator
// FILL_A    | mode 0: collect first-half item codes into mask_a
// FILL_B    | mode 0: collect second-half item codes into mask_b
// FILL_LINE | mode 1: collect one line into lmask, fold into acc at terminator
// RESOLVE   | score the common-item set x, then step past the terminator
// DONE      | results held until the next start
module day3_rucksack_engine #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int SET_W  = 64,
  parameter int SUM_W  = 32,
  parameter int GROUP  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [SUM_W-1:0]  sum,
  output logic [15:0]       line_count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int IDX_W = $clog2(SET_W);
  localparam int GRP_W = (GROUP > 2) ? $clog2(GROUP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_FILL_A, S_FILL_B, S_FILL_LINE, S_RESOLVE, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  line_start_q, line_start_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [GRP_W-1:0]   grp_q, grp_d;
  logic [SET_W-1:0]   mask_a_q, mask_a_d;
  logic [SET_W-1:0]   mask_b_q, mask_b_d;
  logic [SET_W-1:0]   lmask_q, lmask_d;
  logic [SET_W-1:0]   acc_q, acc_d;
  logic [SET_W-1:0]   x_q, x_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [15:0]        lc_q, lc_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               code_ok;
  logic [SET_W-1:0]   code_bit;
  logic               addr_max;
  logic [ADDR_W-1:0]  half;
  logic               half_last;
  logic [SET_W-1:0]   mask_b_next;
  logic               x_seen;
  logic               x_multi;
  logic [IDX_W-1:0]   x_idx;

  assign rom_addr   = addr_q;
  assign sum        = sum_q;
  assign line_count = lc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

  // Decode the current ROM word into a one-hot item bit; invalid codes give no bit.
  always_comb begin
    code_ok     = (rom_data != '0) && (int'(rom_data) < SET_W);
    code_bit    = code_ok ? (SET_W'(1) << rom_data) : '0;
    addr_max    = (addr_q == '1);
    half        = len_q[LEN_W-1:1];
    half_last   = (cnt_q == half - ADDR_W'(1));
    mask_b_next = mask_b_q | code_bit;
  end

  // Classify the common-item set as empty, single (with its index) or multiple.
  always_comb begin
    x_seen  = 1'b0;
    x_multi = 1'b0;
    x_idx   = '0;
    for (int i = 0; i < SET_W; i++) begin
      if (x_q[i]) begin
        if (x_seen) x_multi = 1'b1;
        x_seen = 1'b1;
        x_idx  = IDX_W'(i);
      end
    end
  end

  // Next-state and datapath decisions for every state.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    addr_d       = addr_q;
    line_start_d = line_start_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    grp_d        = grp_q;
    mask_a_d     = mask_a_q;
    mask_b_d     = mask_b_q;
    lmask_d      = lmask_q;
    acc_d        = acc_q;
    x_d          = x_q;
    sum_d        = sum_q;
    lc_d         = lc_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d       = mode;
          addr_d       = '0;
          line_start_d = '0;
          len_d        = '0;
          cnt_d        = '0;
          grp_d        = '0;
          mask_a_d     = '0;
          mask_b_d     = '0;
          lmask_d      = '0;
          acc_d        = '0;
          x_d          = '0;
          sum_d        = '0;
          lc_d         = '0;
          err_d        = 1'b0;
          state_d      = mode ? S_FILL_LINE : S_SCAN;
        end
      end

      S_SCAN: begin
        if (rom_data != '0) begin
          if (addr_max) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            len_d  = len_q + LEN_W'(1);
          end
        end else if (len_q == '0) begin
          state_d = S_DONE;
        end else if (len_q[0]) begin
          // Odd-length line cannot be split in two: flag it and move on.
          err_d = 1'b1;
          if (addr_max) begin
            state_d = S_DONE;
          end else begin
            addr_d       = addr_q + ADDR_W'(1);
            line_start_d = addr_q + ADDR_W'(1);
            len_d        = '0;
          end
        end else begin
          addr_d  = line_start_q;
          cnt_d   = '0;
          state_d = S_FILL_A;
        end
      end

      // Fill addresses always stay below the terminator, so no overflow here.
      S_FILL_A: begin
        if (code_ok) mask_a_d = mask_a_q | code_bit;
        else         err_d    = 1'b1;
        addr_d = addr_q + ADDR_W'(1);
        if (half_last) begin
          cnt_d   = '0;
          state_d = S_FILL_B;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end

      S_FILL_B: begin
        mask_b_d = mask_b_next;
        if (!code_ok) err_d = 1'b1;
        addr_d = addr_q + ADDR_W'(1);
        if (half_last) begin
          cnt_d   = '0;
          x_d     = mask_a_q & mask_b_next;
          state_d = S_RESOLVE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end

      S_FILL_LINE: begin
        if (rom_data != '0) begin
          if (code_ok) lmask_d = lmask_q | code_bit;
          else         err_d   = 1'b1;
          len_d = len_q + LEN_W'(1);
          if (addr_max) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end else if (len_q == '0) begin
          if (grp_q != '0) err_d = 1'b1;
          state_d = S_DONE;
        end else if (grp_q == GRP_W'(GROUP - 1)) begin
          // Last line of the group: address stays on the terminator for RESOLVE.
          x_d     = acc_q & lmask_q;
          lmask_d = '0;
          len_d   = '0;
          state_d = S_RESOLVE;
        end else begin
          acc_d   = (grp_q == '0) ? lmask_q : (acc_q & lmask_q);
          lmask_d = '0;
          len_d   = '0;
          grp_d   = grp_q + GRP_W'(1);
          if (addr_max) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      S_RESOLVE: begin
        if (x_seen && !x_multi) sum_d = sum_q + SUM_W'(x_idx);
        else                    err_d = 1'b1;
        lc_d     = lc_q + 16'd1;
        mask_a_d = '0;
        mask_b_d = '0;
        lmask_d  = '0;
        acc_d    = '0;
        x_d      = '0;
        len_d    = '0;
        grp_d    = '0;
        if (addr_max) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          addr_d       = addr_q + ADDR_W'(1);
          line_start_d = addr_q + ADDR_W'(1);
          state_d      = mode_q ? S_FILL_LINE : S_SCAN;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      addr_q       <= '0;
      line_start_q <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      grp_q        <= '0;
      mask_a_q     <= '0;
      mask_b_q     <= '0;
      lmask_q      <= '0;
      acc_q        <= '0;
      x_q          <= '0;
      sum_q        <= '0;
      lc_q         <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      line_start_q <= line_start_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      grp_q        <= grp_d;
      mask_a_q     <= mask_a_d;
      mask_b_q     <= mask_b_d;
      lmask_q      <= lmask_d;
      acc_q        <= acc_d;
      x_q          <= x_d;
      sum_q        <= sum_d;
      lc_q         <= lc_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_day3_rucksack_engine.sv
// Directed bench for day3_rucksack_engine with a behavioural asynchronous ROM.
module tb_day3_rucksack_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic [31:0] sum;
  logic [15:0] line_count;
  logic        busy;
  logic        done;
  logic        err;

  logic [7:0]  rom_mem [0:4095];

  int checks;
  int failures;

  day3_rucksack_engine #(
    .ADDR_W(12), .DATA_W(8), .SET_W(64), .SUM_W(32), .GROUP(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .rom_addr(rom_addr), .rom_data(rom_data), .sum(sum),
    .line_count(line_count), .busy(busy), .done(done), .err(err)
  );

  assign rom_data = rom_mem[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First byte of the list sits in the most significant used byte of v.
  task automatic load_rom(input logic [127:0] v, input int n);
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'd0;
    for (int i = 0; i < n; i++) rom_mem[i] = v[8*(n-1-i) +: 8];
  endtask

  task automatic pulse_start(input logic m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (done) ok = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (sum !== 32'd0) begin failures++; $display("FAIL reset_sum got=%0d want=0", sum); end
    checks++; if (rom_addr !== 12'd0) begin failures++; $display("FAIL reset_addr got=%0d want=0", rom_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || line_count !== 16'd0)
      begin failures++; $display("FAIL idle_after_reset busy=%b done=%b err=%b lc=%0d want all 0", busy, done, err, line_count); end
  endtask

  // Two lines: common items 2 and 7. Start edge counts as clock 1; done rises at clock 22.
  task automatic test_half_split;
    int done_at;
    load_rom({8'd1,8'd2,8'd3,8'd2,8'd0,8'd5,8'd7,8'd7,8'd9,8'd0,8'd0}, 11);
    done_at = 0;
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL half_busy_after_start got=%b want=1", busy); end
      end
      if (done && done_at == 0) done_at = k;
    end
    checks++; if (done_at != 22) begin failures++; $display("FAIL half_done_latency got=%0d want=22", done_at); end
    checks++; if (sum !== 32'd9) begin failures++; $display("FAIL half_sum got=%0d want=9", sum); end
    checks++; if (line_count !== 16'd2) begin failures++; $display("FAIL half_lines got=%0d want=2", line_count); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL half_err got=%b want=0", err); end
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL half_hold busy=%b done=%b want 0/1", busy, done); end
  endtask

  // Start and mode toggled mid-run must not disturb the run.
  task automatic test_busy_ignore;
    int done_at;
    done_at = 0;
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) start = 1'b0;
      if (k == 5) begin start = 1'b1; mode = 1'b1; end
      if (k == 6) start = 1'b0;
      if (done && done_at == 0) done_at = k;
    end
    mode = 1'b0;
    checks++; if (done_at != 22) begin failures++; $display("FAIL busy_ignore_latency got=%0d want=22", done_at); end
    checks++; if (sum !== 32'd9 || line_count !== 16'd2) begin failures++; $display("FAIL busy_ignore_result sum=%0d lc=%0d want 9/2", sum, line_count); end
  endtask

  task automatic test_group;
    logic ok;
    load_rom({8'd4,8'd6,8'd0,8'd6,8'd9,8'd0,8'd1,8'd6,8'd0,8'd0}, 10);
    pulse_start(1'b1);
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL group_timeout done=%b want=1", done); end
    checks++; if (sum !== 32'd6) begin failures++; $display("FAIL group_sum got=%0d want=6", sum); end
    checks++; if (line_count !== 16'd1) begin failures++; $display("FAIL group_lines got=%0d want=1", line_count); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL group_err got=%b want=0", err); end
  endtask

  task automatic test_odd_skip;
    logic ok;
    load_rom({8'd1,8'd2,8'd3,8'd0,8'd2,8'd2,8'd0,8'd0}, 8);
    pulse_start(1'b0);
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL odd_timeout done=%b want=1", done); end
    checks++; if (err !== 1'b1 || sum !== 32'd2 || line_count !== 16'd1)
      begin failures++; $display("FAIL odd_result err=%b sum=%0d lc=%0d want 1/2/1", err, sum, line_count); end
  endtask

  // Two common items -> error; the next start (straight from DONE) clears err.
  task automatic test_multi_bit;
    logic ok;
    load_rom({8'd1,8'd2,8'd1,8'd2,8'd0,8'd0}, 6);
    pulse_start(1'b0);
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL multi_timeout done=%b want=1", done); end
    checks++; if (err !== 1'b1 || sum !== 32'd0 || line_count !== 16'd1)
      begin failures++; $display("FAIL multi_result err=%b sum=%0d lc=%0d want 1/0/1", err, sum, line_count); end
    load_rom({8'd3,8'd7,8'd7,8'd4,8'd0,8'd0}, 6);
    pulse_start(1'b0);
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL restart_timeout done=%b want=1", done); end
    checks++; if (err !== 1'b0 || sum !== 32'd7 || line_count !== 16'd1)
      begin failures++; $display("FAIL restart_result err=%b sum=%0d lc=%0d want 0/7/1", err, sum, line_count); end
  endtask

  // Code 70 is outside the 64-bit set: ignored and flagged.
  task automatic test_bad_code;
    logic ok;
    load_rom({8'd70,8'd2,8'd2,8'd2,8'd0,8'd0}, 6);
    pulse_start(1'b0);
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL badcode_timeout done=%b want=1", done); end
    checks++; if (err !== 1'b1 || sum !== 32'd2 || line_count !== 16'd1)
      begin failures++; $display("FAIL badcode_result err=%b sum=%0d lc=%0d want 1/2/1", err, sum, line_count); end
  endtask

  task automatic test_partial_group;
    logic ok;
    load_rom({8'd5,8'd0,8'd5,8'd0,8'd0}, 5);
    pulse_start(1'b1);
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL partial_timeout done=%b want=1", done); end
    checks++; if (err !== 1'b1 || sum !== 32'd0 || line_count !== 16'd0)
      begin failures++; $display("FAIL partial_result err=%b sum=%0d lc=%0d want 1/0/0", err, sum, line_count); end
  endtask

  // Reset asserted while the first line is in FILL_B (after clock 8 of the run).
  task automatic test_reset_mid_run;
    logic ok;
    load_rom({8'd1,8'd2,8'd3,8'd2,8'd0,8'd5,8'd7,8'd7,8'd9,8'd0,8'd0}, 11);
    pulse_start(1'b0);
    repeat (7) @(posedge clk);
    #1;
    checks++; if (rom_addr !== 12'd2 || busy !== 1'b1) begin failures++; $display("FAIL midrun_pre addr=%0d busy=%b want 2/1", rom_addr, busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rom_addr !== 12'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || sum !== 32'd0 || line_count !== 16'd0)
      begin failures++; $display("FAIL midrun_reset addr=%0d busy=%b done=%b err=%b sum=%0d lc=%0d want all 0", rom_addr, busy, done, err, sum, line_count); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || rom_addr !== 12'd0) begin failures++; $display("FAIL midrun_idle busy=%b addr=%0d want 0/0", busy, rom_addr); end
    pulse_start(1'b0);
    wait_done(200, ok);
    checks++; if (!ok || sum !== 32'd9 || line_count !== 16'd2 || err !== 1'b0)
      begin failures++; $display("FAIL midrun_rerun done=%b sum=%0d lc=%0d err=%b want 1/9/2/0", done, sum, line_count, err); end
  endtask

  // Nonzero words fill the whole ROM: address must stop at the top, not wrap.
  task automatic test_addr_overflow;
    logic ok;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'd1;
    pulse_start(1'b0);
    wait_done(5000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL overflow_timeout done=%b want=1", done); end
    checks++; if (err !== 1'b1 || rom_addr !== 12'd4095 || line_count !== 16'd0 || sum !== 32'd0)
      begin failures++; $display("FAIL overflow_result err=%b addr=%0d lc=%0d sum=%0d want 1/4095/0/0", err, rom_addr, line_count, sum); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'd0;
    test_reset();
    test_half_split();
    test_busy_ignore();
    test_group();
    test_odd_skip();
    test_multi_bit();
    test_bad_code();
    test_partial_group();
    test_reset_mid_run();
    test_addr_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
